// File: rtl/trigger_sequencer_if.sv
// Control/status bundle between a trigger_sequencer and its host.
// master = host side, slave = sequencer side.
interface trigger_sequencer_if #(
    parameter int GPIO_DATA_WIDTH = 16,
    parameter int CNTR_WIDTH      = 32
);
    localparam int SEL_W = (GPIO_DATA_WIDTH > 1) ? $clog2(GPIO_DATA_WIDTH) : 1;

    logic [GPIO_DATA_WIDTH-1:0] gpio_data;
    logic                       soft_trig;
    logic                       arm;
    logic                       abort;
    logic [SEL_W-1:0]           cfg_src_sel;
    logic                       cfg_edge;
    logic [CNTR_WIDTH-1:0]      cfg_pre_cnt;
    logic [CNTR_WIDTH-1:0]      cfg_post_cnt;
    logic [CNTR_WIDTH-1:0]      cfg_holdoff;
    logic                       trigger;
    logic                       acquire;
    logic                       done;
    logic [2:0]                 state;

    modport master (
        output gpio_data, soft_trig, arm, abort,
        output cfg_src_sel, cfg_edge, cfg_pre_cnt, cfg_post_cnt, cfg_holdoff,
        input  trigger, acquire, done, state
    );

    modport slave (
        input  gpio_data, soft_trig, arm, abort,
        input  cfg_src_sel, cfg_edge, cfg_pre_cnt, cfg_post_cnt, cfg_holdoff,
        output trigger, acquire, done, state
    );
endinterface

// File: rtl/trigger_sequencer.sv
// Armed PRE/WAIT/POST/DONE/HOLDOFF acquisition sequencer with GPIO or software trigger.
// Define TRIG_GPIO_SYNC_EN to put a two-flop synchronizer in front of the GPIO edge detector.
module trigger_sequencer #(
    parameter int GPIO_DATA_WIDTH = 16,
    parameter int CNTR_WIDTH      = 32
) (
    input logic                aclk,
    input logic                areset,
    trigger_sequencer_if.slave bus
);
    localparam int SEL_W = (GPIO_DATA_WIDTH > 1) ? $clog2(GPIO_DATA_WIDTH) : 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PRE     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_POST    = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_HOLDOFF = 3'd5;

    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [CNTR_WIDTH-1:0] sat_dec(input logic [CNTR_WIDTH-1:0] v);
        return (v == '0) ? v : v - CNT_ONE;
    endfunction

    logic [2:0]                 state_q, state_d;
    logic [CNTR_WIDTH-1:0]      cnt_q, cnt_d;
    logic [CNTR_WIDTH-1:0]      post_q, holdoff_q;
    logic [SEL_W-1:0]           src_sel_q;
    logic                       edge_q;
    logic [GPIO_DATA_WIDTH-1:0] gpio_in;
    logic [GPIO_DATA_WIDTH-1:0] gpio_cur_p2, gpio_prev_p3;
    logic                       hw_ev, trig_ev, cfg_load;

`ifdef TRIG_GPIO_SYNC_EN
    logic [GPIO_DATA_WIDTH-1:0] gpio_meta_p0, gpio_sync_p1;

    // stage p0/p1: metastability filter, left unreset
    always_ff @(posedge aclk) begin
        gpio_meta_p0 <= bus.gpio_data;
        gpio_sync_p1 <= gpio_meta_p0;
    end
    assign gpio_in = gpio_sync_p1;
`else
    assign gpio_in = bus.gpio_data;
`endif

    // stage p2/p3: current and previous sample of the GPIO lines
    always_ff @(posedge aclk) begin
        if (areset) begin
            gpio_cur_p2  <= '0;
            gpio_prev_p3 <= '0;
        end else begin
            gpio_cur_p2  <= gpio_in;
            gpio_prev_p3 <= gpio_cur_p2;
        end
    end

    assign hw_ev = edge_q ? (~gpio_cur_p2[src_sel_q] &  gpio_prev_p3[src_sel_q])
                          : ( gpio_cur_p2[src_sel_q] & ~gpio_prev_p3[src_sel_q]);
    assign trig_ev  = hw_ev | bus.soft_trig;
    assign cfg_load = ~bus.abort & bus.arm & (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // pre length goes straight into the counter, so it needs no shadow copy
                    if (bus.arm) begin
                        state_d = ST_PRE;
                        cnt_d   = bus.cfg_pre_cnt;
                    end
                end
                ST_PRE: begin
                    cnt_d = sat_dec(cnt_q);
                    if (cnt_q == '0) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (trig_ev) begin
                        state_d = ST_POST;
                        cnt_d   = post_q;
                    end
                end
                ST_POST: begin
                    cnt_d = sat_dec(cnt_q);
                    if (cnt_q == '0) state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = holdoff_q;
                end
                ST_HOLDOFF: begin
                    cnt_d = sat_dec(cnt_q);
                    if (cnt_q == '0) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            post_q    <= '0;
            holdoff_q <= '0;
            src_sel_q <= '0;
            edge_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cfg_load) begin
                post_q    <= bus.cfg_post_cnt;
                holdoff_q <= bus.cfg_holdoff;
                src_sel_q <= bus.cfg_src_sel;
                edge_q    <= bus.cfg_edge;
            end
        end
    end

    // outputs are forced low while reset is held, even before the first reset edge
    assign bus.trigger = ~areset & ~bus.abort & (state_q == ST_WAIT) & trig_ev;
    assign bus.acquire = ~areset & ((state_q == ST_PRE) | (state_q == ST_WAIT) | (state_q == ST_POST));
    assign bus.done    = ~areset & ((state_q == ST_DONE) | (state_q == ST_HOLDOFF));
    assign bus.state   = areset ? ST_IDLE : state_q;
endmodule

// File: tb/tb_trigger_sequencer.sv
// Randomized + directed bench for trigger_sequencer against a phase-length reference model.
module tb_trigger_sequencer;
`ifdef TRIG_GPIO_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int NCYC = 4096;

    logic aclk = 1'b0;
    logic areset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_n   = 0;

    always #5 aclk = ~aclk;

    trigger_sequencer_if #(.GPIO_DATA_WIDTH(16), .CNTR_WIDTH(32)) bus ();

    trigger_sequencer #(.GPIO_DATA_WIDTH(16), .CNTR_WIDTH(32)) dut (
        .aclk  (aclk),
        .areset(areset),
        .bus   (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc_n, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] pin_h [NCYC];
    bit          rst_h [NCYC];
    int m_state = 0, m_left = 0, m_post = 0, m_hold = 0, m_sel = 0;
    bit m_edge = 0;

    // value of the selected line as seen by the edge detector in cycle tt
    function automatic bit cur_at(input int tt, input int sel);
        if (tt < 1) return 1'b0;
        if (rst_h[tt-1]) return 1'b0;
        if (tt - LAT < 0) return 1'b0;
        return pin_h[tt-LAT][sel];
    endfunction

    function automatic bit prev_at(input int tt, input int sel);
        if (tt < 1) return 1'b0;
        if (rst_h[tt-1]) return 1'b0;
        return cur_at(tt - 1, sel);
    endfunction

    always @(negedge aclk) begin
        bit rst, ab, cur, prv, hw, ev, e_trig, e_acq, e_done;
        int e_state;
        if (cyc_n < NCYC) begin
            pin_h[cyc_n] = bus.gpio_data;
            rst_h[cyc_n] = areset;
            rst = areset;
            ab  = bus.abort;
            cur = cur_at(cyc_n, m_sel);
            prv = prev_at(cyc_n, m_sel);
            hw  = m_edge ? (!cur && prv) : (cur && !prv);
            ev  = hw || bus.soft_trig;
            e_trig  = !rst && !ab && (m_state == 2) && ev;
            e_state = rst ? 0 : m_state;
            e_acq   = !rst && (m_state >= 1) && (m_state <= 3);
            e_done  = !rst && (m_state >= 4) && (m_state <= 5);
            check("model_trigger", bus.trigger, e_trig);
            check("model_state",   bus.state,   e_state);
            check("model_acquire", bus.acquire, e_acq);
            check("model_done",    bus.done,    e_done);
            if (rst) begin
                m_state = 0; m_left = 0; m_post = 0; m_hold = 0; m_sel = 0; m_edge = 0;
            end else if (ab) begin
                m_state = 0;
            end else begin
                case (m_state)
                    0: if (bus.arm) begin
                        m_state = 1;
                        m_left  = int'(bus.cfg_pre_cnt) + 1;
                        m_post  = int'(bus.cfg_post_cnt);
                        m_hold  = int'(bus.cfg_holdoff);
                        m_sel   = int'(bus.cfg_src_sel);
                        m_edge  = bus.cfg_edge;
                    end
                    1: begin m_left--; if (m_left == 0) m_state = 2; end
                    2: if (ev) begin m_state = 3; m_left = m_post + 1; end
                    3: begin m_left--; if (m_left == 0) m_state = 4; end
                    4: begin m_state = 5; m_left = m_hold + 1; end
                    5: begin m_left--; if (m_left == 0) m_state = 0; end
                    default: m_state = 0;
                endcase
            end
        end
        cyc_n++;
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_cfg(input int pre, input int post, input int hold, input int sel, input bit edg);
        bus.cfg_pre_cnt  = pre;
        bus.cfg_post_cnt = post;
        bus.cfg_holdoff  = hold;
        bus.cfg_src_sel  = 4'(sel);
        bus.cfg_edge     = edg;
    endtask

    task automatic go_idle(input logic [15:0] g);
        cyc();
        bus.arm = 0; bus.soft_trig = 0; bus.abort = 1; bus.gpio_data = g;
        cyc();
        bus.abort = 0;
        repeat (4) cyc();
    endtask

    task automatic lit(input string name, input int st, input int trig);
        #2;
        check({name, "_state"}, bus.state, st);
        check({name, "_trig"}, bus.trigger, trig);
    endtask

    function automatic int exp_basic(input int k);
        if (k <= 5)  return 1;
        if (k <= 10) return 2;
        if (k <= 14) return 3;
        if (k == 15) return 4;
        if (k <= 18) return 5;
        return 0;
    endfunction

    int rst_left;

    initial begin
        areset = 1;
        bus.gpio_data = '0; bus.soft_trig = 0; bus.arm = 0; bus.abort = 0;
        set_cfg(0, 0, 0, 0, 0);
        repeat (5) cyc();
        #2;
        check("reset_state", bus.state, 0);
        check("reset_trig", bus.trigger, 0);
        check("reset_acq", bus.acquire, 0);
        check("reset_done", bus.done, 0);
        cyc();
        areset = 0;
        repeat (4) cyc();

        // timeline: pre=4 post=3 holdoff=2, soft trigger at cycle 10
        go_idle(16'h0000);
        set_cfg(4, 3, 2, 0, 0);
        bus.arm = 1;
        for (int k = 1; k <= 19; k++) begin
            cyc();
            bus.arm = 0;
            set_cfg(7, 9, 6, 3, 1);
            bus.soft_trig = (k == 10);
            lit("basic", exp_basic(k), (k == 10) ? 1 : 0);
        end
        bus.soft_trig = 0;

        // GPIO bit 5 rising edge in WAIT
        go_idle(16'h0000);
        set_cfg(0, 0, 0, 5, 0);
        bus.arm = 1;
        cyc(); bus.arm = 0; lit("gpio_pre", 1, 0);
        cyc(); lit("gpio_wait", 2, 0);
        cyc(); bus.gpio_data = 16'h0020; lit("gpio_edge", 2, 0);
        for (int j = 1; j <= LAT; j++) begin
            cyc(); lit("gpio_lat", 2, (j == LAT) ? 1 : 0);
        end
        cyc(); lit("gpio_post", 3, 0);

        // falling edge on bit 5 (and rising on bit 4) must not fire
        go_idle(16'h0020);
        set_cfg(0, 0, 0, 5, 0);
        bus.arm = 1;
        cyc(); bus.arm = 0;
        cyc();
        cyc(); bus.gpio_data = 16'h0010; lit("fall", 2, 0);
        for (int j = 0; j < LAT + 2; j++) begin
            cyc(); lit("fall", 2, 0);
        end

        // triggers during PRE are ignored
        go_idle(16'h0000);
        set_cfg(3, 0, 0, 5, 0);
        bus.arm = 1;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            bus.arm = 0;
            if (k == 1) bus.gpio_data = 16'h0020;
            bus.soft_trig = (k <= 4);
            lit("pre_ign", (k <= 4) ? 1 : 2, 0);
        end

        // abort beats soft trigger in WAIT
        go_idle(16'h0000);
        set_cfg(0, 2, 2, 0, 0);
        bus.arm = 1;
        cyc(); bus.arm = 0;
        cyc(); bus.abort = 1; bus.soft_trig = 1; lit("abort", 2, 0);
        cyc(); bus.abort = 0; lit("abort_next", 0, 0);
        bus.soft_trig = 0;

        // zero lengths: one cycle per state, arm in HOLDOFF ignored
        go_idle(16'h0000);
        set_cfg(0, 0, 0, 0, 0);
        bus.arm = 1;
        cyc(); bus.arm = 0; lit("zero_pre", 1, 0);
        cyc(); bus.soft_trig = 1; lit("zero_wait", 2, 1);
        cyc(); bus.soft_trig = 0; lit("zero_post", 3, 0);
        cyc(); lit("zero_done", 4, 0);
        cyc(); bus.arm = 1; lit("zero_hold", 5, 0);
        cyc(); bus.arm = 0; lit("zero_idle", 0, 0);
        cyc(); lit("zero_idle2", 0, 0);

        // reset during POST, soft trigger held afterwards
        go_idle(16'h0000);
        set_cfg(0, 5, 0, 0, 0);
        bus.arm = 1;
        cyc(); bus.arm = 0;
        cyc(); bus.soft_trig = 1;
        cyc(); bus.soft_trig = 0; areset = 1; lit("rst_post", 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(); areset = 0; bus.soft_trig = 1; lit("rst_after", 0, 0);
            check("rst_after_acq", bus.acquire, 0);
            check("rst_after_done", bus.done, 0);
        end
        bus.soft_trig = 0;

        // randomized traffic
        rst_left = 0;
        for (int i = 0; i < 2500; i++) begin
            cyc();
            bus.arm       = ($urandom_range(0, 7) == 0);
            bus.abort     = ($urandom_range(0, 49) == 0);
            bus.soft_trig = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) bus.gpio_data = 16'($urandom);
            if ($urandom_range(0, 2) == 0)
                set_cfg($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                        $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
            areset = (rst_left > 0);
        end
        cyc();
        areset = 0; bus.arm = 0; bus.abort = 0; bus.soft_trig = 0;
        repeat (3) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
